// File: rtl/reg_file_pkg.sv
// Shared MIPS decode-stage constants: register address width, datapath width
// and the hardwired-zero register index.
package reg_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_sign_extend.sv
// Parameterised immediate sign extender (IMM_W -> DATA_W). It is purely
// combinational, so the branch-offset logic can reuse it without adding a
// pipeline stage.
module sign_extend #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm_in,
    output logic [DATA_W-1:0] imm_out
);

    // Replicate the immediate's top bit into the upper bits.
    assign imm_out = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};

endmodule : sign_extend

// File: rtl/reg_file.sv
// MIPS32 architectural register file: two combinational read ports with
// write-through bypass, one synchronous write port, r0 hardwired to zero,
// plus the decode-stage immediate sign extender.
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::REG_ADDR_W,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_enabled,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    input  logic [IMM_W-1:0]  imm_in,
    output logic [DATA_W-1:0] imm_out
);

    import reg_file_pkg::*;

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // A write only counts when it targets a real (non-zero) register. The same
    // qualifier gates both the array update and the bypass.
    logic wr_hit;
    assign wr_hit = write_enabled && (write_addr != ZERO_ADDR);

    // Next-state of the array: hold everything, overwrite the addressed entry.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_hit) begin
            regs_d[write_addr] = write_data;
        end
    end

    // Storage update; reset (active-low) clears every entry and drops any write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports are identical, so they are built from one generate body.
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = read_addr_1;
    assign rd_addr[1] = read_addr_2;
    assign data_1     = rd_data[0];
    assign data_2     = rd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            // Zero register first, then same-cycle bypass, then the array.
            // The bypass stays live during reset because reads are combinational.
            always_comb begin
                rd_data[gi] = regs_q[rd_addr[gi]];
                if (rd_addr[gi] == ZERO_ADDR) begin
                    rd_data[gi] = '0;
                end else if (wr_hit && (write_addr == rd_addr[gi])) begin
                    rd_data[gi] = write_data;
                end
            end
        end
    endgenerate

    sign_extend #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_sign_extend (
        .imm_in  (imm_in),
        .imm_out (imm_out)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: reset, write/read-back, r0, bypass,
// reset priority, back-to-back writes and sign extension.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enabled;
    logic [31:0] data_1;
    logic [31:0] data_2;
    logic [15:0] imm_in;
    logic [31:0] imm_out;

    int vectors;
    int miscompares;

    reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .read_addr_1   (read_addr_1),
        .read_addr_2   (read_addr_2),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_enabled (write_enabled),
        .data_1        (data_1),
        .data_2        (data_2),
        .imm_in        (imm_in),
        .imm_out       (imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled
    // 1 time unit after it, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        write_addr    = a;
        write_data    = d;
        write_enabled = 1'b1;
        tick();
        write_enabled = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            read_addr_1 = 5'(a);
            read_addr_2 = 5'(31 - a);
            #1;
            vectors++;
            if (data_1 !== 32'h0 || data_2 !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read addr=%0d got d1=%h d2=%h want 00000000", a, data_1, data_2);
            end else
                $display("reset_read addr=%0d d1=%h d2=%h", a, data_1, data_2);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        read_addr_1 = 5'd5;
        read_addr_2 = 5'd31;
        #1;
        vectors++;
        if (data_1 !== 32'hDEADBEEF || data_2 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL write_read got d1=%h d2=%h want deadbeef 12345678", data_1, data_2);
        end else
            $display("write_read d1=%h d2=%h", data_1, data_2);
    endtask

    task automatic test_r0();
        write_addr    = 5'd0;
        write_data    = 32'hFFFFFFFF;
        write_enabled = 1'b1;
        read_addr_1   = 5'd0;
        read_addr_2   = 5'd0;
        #1;
        vectors++;
        if (data_1 !== 32'h0 || data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL r0_write_cycle got d1=%h d2=%h want 00000000", data_1, data_2);
        end else
            $display("r0_write_cycle d1=%h d2=%h", data_1, data_2);
        tick();
        write_enabled = 1'b0;
        #1;
        vectors++;
        if (data_1 !== 32'h0) begin
            miscompares++;
            $display("FAIL r0_after got %h want 00000000", data_1);
        end else
            $display("r0_after d1=%h", data_1);
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h00000001);
        read_addr_1 = 5'd7;
        read_addr_2 = 5'd7;
        #1;
        vectors++;
        if (data_1 !== 32'h1) begin
            miscompares++;
            $display("FAIL bypass_pre got %h want 00000001", data_1);
        end else
            $display("bypass_pre d1=%h", data_1);
        write_addr    = 5'd7;
        write_data    = 32'hA5A5A5A5;
        write_enabled = 1'b1;
        #1;
        vectors++;
        if (data_1 !== 32'hA5A5A5A5 || data_2 !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL bypass_same_cycle got d1=%h d2=%h want a5a5a5a5", data_1, data_2);
        end else
            $display("bypass_same_cycle d1=%h d2=%h", data_1, data_2);
        tick();
        write_enabled = 1'b0;
        write_data    = 32'h0;
        #1;
        vectors++;
        if (data_1 !== 32'hA5A5A5A5 || data_2 !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL bypass_stored got d1=%h d2=%h want a5a5a5a5", data_1, data_2);
        end else
            $display("bypass_stored d1=%h d2=%h", data_1, data_2);
        // Bypass must not leak to a port reading a different register.
        write_addr    = 5'd7;
        write_data    = 32'h0BADF00D;
        write_enabled = 1'b1;
        read_addr_1   = 5'd5;
        read_addr_2   = 5'd7;
        #1;
        vectors++;
        if (data_1 !== 32'hDEADBEEF || data_2 !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL bypass_independent got d1=%h d2=%h want deadbeef 0badf00d", data_1, data_2);
        end else
            $display("bypass_independent d1=%h d2=%h", data_1, data_2);
        write_enabled = 1'b0;
    endtask

    task automatic test_reset_priority();
        do_write(5'd3, 32'h00000055);
        read_addr_1 = 5'd3;
        read_addr_2 = 5'd5;
        #1;
        vectors++;
        if (data_1 !== 32'h55) begin
            miscompares++;
            $display("FAIL rstpri_pre got %h want 00000055", data_1);
        end else
            $display("rstpri_pre d1=%h", data_1);
        rst           = 1'b0;
        write_addr    = 5'd3;
        write_data    = 32'h00000077;
        write_enabled = 1'b1;
        #1;
        vectors++;
        if (data_1 !== 32'h77) begin
            miscompares++;
            $display("FAIL rstpri_bypass got %h want 00000077", data_1);
        end else
            $display("rstpri_bypass d1=%h", data_1);
        tick();
        rst           = 1'b1;
        write_enabled = 1'b0;
        #1;
        vectors++;
        if (data_1 !== 32'h0 || data_2 !== 32'h0) begin
            miscompares++;
            $display("FAIL rstpri_after got d1=%h d2=%h want 00000000", data_1, data_2);
        end else
            $display("rstpri_after d1=%h d2=%h", data_1, data_2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        exp[0] = 32'h11111111;
        exp[1] = 32'h22222222;
        exp[2] = 32'h80000001;
        exp[3] = 32'h7FFFFFFE;
        for (int i = 0; i < 4; i++) begin
            do_write(5'(10 + i), exp[i]);
        end
        for (int i = 0; i < 4; i++) begin
            read_addr_1 = 5'(10 + i);
            read_addr_2 = 5'(13 - i);
            #1;
            vectors++;
            if (data_1 !== exp[i] || data_2 !== exp[3 - i]) begin
                miscompares++;
                $display("FAIL b2b idx=%0d got d1=%h d2=%h want %h %h", i, data_1, data_2, exp[i], exp[3 - i]);
            end else
                $display("b2b idx=%0d d1=%h d2=%h", i, data_1, data_2);
        end
    endtask

    task automatic test_sign_extend();
        logic [15:0] ins  [5];
        logic [31:0] outs [5];
        ins[0] = 16'h7FFF; outs[0] = 32'h00007FFF;
        ins[1] = 16'h8000; outs[1] = 32'hFFFF8000;
        ins[2] = 16'hFFFF; outs[2] = 32'hFFFFFFFF;
        ins[3] = 16'h0000; outs[3] = 32'h00000000;
        ins[4] = 16'h1234; outs[4] = 32'h00001234;
        for (int i = 0; i < 5; i++) begin
            imm_in = ins[i];
            #1;
            vectors++;
            if (imm_out !== outs[i]) begin
                miscompares++;
                $display("FAIL sign_extend in=%h got %h want %h", ins[i], imm_out, outs[i]);
            end else
                $display("sign_extend in=%h out=%h", ins[i], imm_out);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        read_addr_1   = '0;
        read_addr_2   = '0;
        write_addr    = '0;
        write_data    = '0;
        write_enabled = 1'b0;
        imm_in        = '0;
        #2;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_reset_priority();
        test_back_to_back();
        test_sign_extend();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
# reg_file

Architectural register file for the MIPS32 pipeline's decode stage, bundled with the 16→32-bit immediate sign extender that the same stage uses. It provides two combinational read ports (rs, rt operands) and one synchronous write port (writeback stage). Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- IMM_W, 16, immediate input width for the sign extender.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-low; clears the array at the rising edge while 0.
- read_addr_1  input  ADDR_W  read port 1 address (rs).
- read_addr_2  input  ADDR_W  read port 2 address (rt).
- write_addr  input  ADDR_W  write port address.
- write_data  input  DATA_W  write port data.
- write_enabled  input  1  write strobe, active-high.
- data_1  output  DATA_W  read port 1 data.
- data_2  output  DATA_W  read port 2 data.
- imm_in  input  IMM_W  raw immediate (inst[15:0]).
- imm_out  output  DATA_W  sign-extended immediate.

## Operation
- Array: 2**ADDR_W entries × DATA_W bits.
- Write: at the rising clk edge, if rst=1, write_enabled=1 and write_addr≠0, then reg[write_addr] ← write_data. Writes to address 0 are discarded.
- Read: data_N is combinational from read_addr_N.
  - Address 0 always returns 0.
  - Write-through bypass: if write_enabled=1, write_addr==read_addr_N and write_addr≠0, then data_N = write_data in the same cycle, even before the edge. A writeback and a decode of the same register in one cycle therefore sees the new value.
  - Otherwise data_N = reg[read_addr_N].
- Both read ports are independent. Both may address the same register, including the bypassed one.
- Sign extend: imm_out = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in}. Purely combinational, with no dependence on clk or rst.
- Reset: while rst=0, every register is set to 0 at each rising edge. A write presented during reset is ignored, because reset has priority.
- Bypass during reset: the bypass stays active while rst=0, since reads are combinational. The written value is not stored.
- No X on outputs: all outputs have defined values after the first reset edge.

## Timing
- Read latency: 0 cycles (combinational from addresses and write-port inputs).
- Write latency: 1 edge. The value is visible through the array from the cycle after the write edge, and through the bypass in the write cycle itself.
- Reset: after one rising edge with rst=0, all data_N = 0 for any address, provided no bypass hit is occurring.
- Reset mid-operation: any pending write in the reset cycle is lost. Registers written earlier are cleared.
- imm_out: 0-cycle combinational, valid in every cycle.

## Structure
- Shared package (team MIPS package): REG_ADDR_W = 5, DATA_W = 32, REG_ZERO = 5'd0.
- Top module reg_file contains the storage array, write logic and bypass/zero muxes.
- One natural sub-module, sign_extend (parameterised IMM_W → DATA_W). It is instantiated inside reg_file and reusable elsewhere, for example by the branch-offset logic.

## Test plan
- Reset: hold rst=0 for one edge, then read all 32 addresses on both ports → every read is 0x00000000.
- Write and read back: write 0xDEADBEEF to r5 and 0x12345678 to r31 on successive edges. Then read_addr_1=5, read_addr_2=31 → data_1=0xDEADBEEF, data_2=0x12345678.
- r0 immutable: write 0xFFFFFFFF to r0 → data_1 for address 0 reads 0 both in the write cycle and afterwards.
- Bypass: r7 holds 0x1. In the same cycle, present write_addr=7, write_data=0xA5A5A5A5, write_enabled=1 with read_addr_1=read_addr_2=7 → both ports show 0xA5A5A5A5 before the edge, and keep showing it after the edge with write_enabled=0.
- Reset priority: r3 holds 0x55. Assert rst=0 together with a write of 0x77 to r3 → after the edge, r3 reads 0.
- Sign extend: imm_in=0x7FFF → 0x00007FFF; 0x8000 → 0xFFFF8000; 0xFFFF → 0xFFFFFFFF; 0x0000 → 0x00000000.
